// File: rtl/mio_arbiter.sv
// Round-robin arbiter sharing the data-memory/IO bus between the CPU and a DMA requester.
// Each access runs a fixed ACC_CYCLES window and then issues one registered ready pulse.
module mio_arbiter #(
  parameter int unsigned ACC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        MIO_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                mio_ready_q, mio_ready_d;
  logic                dma_ready_q, dma_ready_d;

  logic                pick_dma;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                mem_w_c;
  logic [DATA_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // DMA wins only when alone, or on a tie when the CPU was served last.
  assign pick_dma  = dma_req && (!CPU_MIO || !last_q);
  assign sel_we    = owner_q ? dma_we    : cpu_we;
  assign sel_addr  = owner_q ? dma_addr  : cpu_addr;
  assign sel_wdata = owner_q ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mio_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mio_ready_q <= mio_ready_d;
      dma_ready_q <= dma_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    mio_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    mem_w_c     = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (CPU_MIO || dma_req) begin
          owner_d = pick_dma;
          last_d  = pick_dma;
          cnt_d   = CNT_W'(ACC_CYCLES - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr_c  = sel_addr;
        mem_wdata_c = sel_wdata;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Final window cycle: single write strobe, read capture, ready armed for DONE.
          mem_w_c = sel_we;
          if (owner_q) begin
            dma_rdata_d = mem_rdata;
            dma_ready_d = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            mio_ready_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign MIO_ready = mio_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_w     = mem_w_c;
  assign mem_addr  = mem_addr_c;
  assign mem_wdata = mem_wdata_c;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule
